// File: rtl/fp32_to_int_conv_if.sv
// Valid/ready stream bundle for the FP32-to-integer converter.
// The master drives operands and accepts results; the slave is the converter.
interface fp32_to_int_conv_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_overflow;
    logic        out_inexact;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_overflow, out_inexact
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_overflow, out_inexact
    );
endinterface

// File: rtl/fp32_to_int_conv.sv
// Truncating FP32 -> signed 32-bit integer / fixed point (FRAC_BITS fractional bits); FP32_TO_INT_SAT_EN selects saturating overflow values.
// Latency: 2 cycles from accept to out_valid, 1 word/cycle sustained.
// Backpressure: two-stage valid/ready pipeline, in_ready derived combinationally from out_ready, no skid buffer.
module fp32_to_int_conv #(
    parameter int FRAC_BITS = 0
) (
    input  logic              clk,
    input  logic              rst,
    fp32_to_int_conv_if.slave bus
);
    logic              sgn;
    logic [7:0]        expn;
    logic [22:0]       frac;
    logic [7:0]        e_eff;
    logic [23:0]       m;
    logic [9:0]        exp_sum;
    logic signed [9:0] k;
    logic [9:0]        rsh;
    logic              nan_inf;
    logic              big;
    logic              exact_min;
    logic              ovf;
    logic [32:0]       mag;
    logic              inexact;

    assign sgn       = bus.in_data[31];
    assign expn      = bus.in_data[30:23];
    assign frac      = bus.in_data[22:0];
    assign e_eff     = (expn == 8'd0) ? 8'd1 : expn;
    assign m         = {expn != 8'd0, frac};
    assign exp_sum   = {2'b00, e_eff} + 10'(FRAC_BITS);
    assign k         = $signed(exp_sum) - 10'sd150;
    assign nan_inf   = (expn == 8'hFF);
    // Range is decided from the exponent alone; only -2^31 exactly is representable at the boundary.
    assign big       = (exp_sum >= 10'd158);
    assign exact_min = sgn && (exp_sum == 10'd158) && (frac == 23'd0);
    assign ovf       = nan_inf || (big && !exact_min);

    always_comb begin
        mag     = '0;
        inexact = 1'b0;
        rsh     = '0;
        if (!k[9]) begin
            if (k <= 10'sd8) begin
                mag = {9'd0, m} << k[3:0];
            end else begin
                mag = {1'b1, 32'd0};
            end
        end else begin
            rsh = 10'(-k);
            if (rsh >= 10'd24) begin
                inexact = |m;
            end else begin
                mag     = {9'd0, m >> rsh[4:0]};
                inexact = |(m & ~(24'hFF_FFFF << rsh[4:0]));
            end
        end
    end

    logic        s1_valid;
    logic        s1_sign;
    logic [32:0] s1_mag;
    logic        s1_inexact;
    logic        s1_ovf;
`ifdef FP32_TO_INT_SAT_EN
    logic        s1_nan;
`endif
    logic        s2_valid;
    logic [31:0] s2_data;
    logic        s2_ovf;
    logic        s2_inexact;
    logic        s1_load;
    logic        s2_load;
    logic        ovf_any;
    logic [31:0] res;

    assign s2_load      = !s2_valid || bus.out_ready;
    assign s1_load      = !s1_valid || s2_load;
    assign bus.in_ready = !rst && s1_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_mag     <= '0;
            s1_inexact <= 1'b0;
            s1_ovf     <= 1'b0;
`ifdef FP32_TO_INT_SAT_EN
            s1_nan     <= 1'b0;
`endif
        end else if (s1_load) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign    <= sgn;
                s1_mag     <= mag;
                s1_inexact <= inexact;
                s1_ovf     <= ovf;
`ifdef FP32_TO_INT_SAT_EN
                s1_nan     <= nan_inf && (frac != 23'd0);
`endif
            end
        end
    end

    // Bit 32 of the magnitude flags values beyond the 32-bit range.
    assign ovf_any = s1_ovf || s1_mag[32];

    always_comb begin
        res = s1_sign ? -s1_mag[31:0] : s1_mag[31:0];
        if (ovf_any) begin
`ifdef FP32_TO_INT_SAT_EN
            res = (s1_nan || !s1_sign) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
            res = 32'h8000_0000;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            s2_ovf     <= 1'b0;
            s2_inexact <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data    <= res;
                s2_ovf     <= ovf_any;
                s2_inexact <= s1_inexact;
            end
        end
    end

    assign bus.out_valid    = s2_valid;
    assign bus.out_data     = s2_data;
    assign bus.out_overflow = s2_ovf;
    assign bus.out_inexact  = s2_inexact;
endmodule

// File: tb/tb_fp32_to_int_conv.sv
// Bench for fp32_to_int_conv: FRAC_BITS=0 and FRAC_BITS=8 instances, vector table plus stall and reset sequences.
module tb_fp32_to_int_conv;
    typedef struct {
        bit          f8;
        logic [31:0] din;
        logic [31:0] dout;
        logic        ovf;
        logic        inx;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        o;
        logic        x;
        int          acc;
        bit          lat;
    } exp_t;

`ifdef FP32_TO_INT_SAT_EN
    localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_POS = 32'h8000_0000;
`endif
    localparam logic [31:0] OVF_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp32_to_int_conv_if if0();
    fp32_to_int_conv_if if8();

    fp32_to_int_conv #(.FRAC_BITS(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    fp32_to_int_conv #(.FRAC_BITS(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q0[$];
    exp_t q8[$];
    exp_t nxt0;
    exp_t nxt8;
    bit   acc0;
    bit   acc8;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic pop_check(input string tag, input bit which, input logic [31:0] d,
                             input logic o, input logic x);
        exp_t e;
        checks++;
        if ((which ? q8.size() : q0.size()) == 0) begin
            failures++;
            $display("FAIL %s_unexpected_output: got %h expected no output", tag, d);
            return;
        end
        if (which) e = q8.pop_front();
        else       e = q0.pop_front();
        chk({tag, "_data"}, d, e.d);
        chk({tag, "_ovf"}, {31'd0, o}, {31'd0, e.o});
        chk({tag, "_inexact"}, {31'd0, x}, {31'd0, e.x});
        if (e.lat) chk({tag, "_latency"}, cyc - e.acc, 32'd2);
    endtask

    // Called just after a falling edge; samples one time unit before the rising edge.
    task automatic sample();
        #4;
        cyc++;
        acc0 = if0.in_valid && if0.in_ready;
        acc8 = if8.in_valid && if8.in_ready;
        if (acc0) begin
            nxt0.acc = cyc;
            q0.push_back(nxt0);
        end
        if (acc8) begin
            nxt8.acc = cyc;
            q8.push_back(nxt8);
        end
        if (if0.out_valid && if0.out_ready)
            pop_check("f0", 1'b0, if0.out_data, if0.out_overflow, if0.out_inexact);
        if (if8.out_valid && if8.out_ready)
            pop_check("f8", 1'b1, if8.out_data, if8.out_overflow, if8.out_inexact);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v;
        int          idx;
        int          guard;
        int          sent;
        logic [31:0] bp_w [6];

        if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b1;
        if8.in_valid = 1'b0; if8.in_data = '0; if8.out_ready = 1'b1;
        nxt0 = '{32'd0, 1'b0, 1'b0, 0, 1'b0};
        nxt8 = nxt0;

        vecs.push_back('{1'b0, 32'h40490FDB, 32'h0000_0003, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 32'hC0F00000, 32'hFFFF_FFF9, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 32'hCF000000, 32'h8000_0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h4F000000, OVF_POS,       1'b1, 1'b0});
        vecs.push_back('{1'b0, 32'h7FC00000, OVF_POS,       1'b1, 1'b0});
        vecs.push_back('{1'b0, 32'hFF800000, OVF_NEG,       1'b1, 1'b0});
        vecs.push_back('{1'b0, 32'h7F800000, OVF_POS,       1'b1, 1'b0});
        vecs.push_back('{1'b0, 32'h00000000, 32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h80000000, 32'h0000_0000, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'h00000001, 32'h0000_0000, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 32'hBF000000, 32'h0000_0000, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 32'h4EFFFFFF, 32'h7FFF_FF80, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'hCEFFFFFF, 32'h8000_0080, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 32'hCF000001, OVF_NEG,       1'b1, 1'b0});
        vecs.push_back('{1'b0, 32'h3F800000, 32'h0000_0001, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'h3FC00000, 32'h0000_0180, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'h3B800000, 32'h0000_0001, 1'b0, 1'b0});
        // 0xBB800000 is -2^-8, one LSB below zero at 8 fractional bits
        vecs.push_back('{1'b1, 32'hBB800000, 32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'hCB000000, 32'h8000_0000, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 32'h4B000000, OVF_POS,       1'b1, 1'b0});
        vecs.push_back('{1'b1, 32'h00400000, 32'h0000_0000, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 32'h47000000, 32'h0080_0000, 1'b0, 1'b0});

        // Reset state
        @(negedge clk);
        sample();
        chk("rst_in_ready0", {31'd0, if0.in_ready}, 32'd0);
        chk("rst_in_ready8", {31'd0, if8.in_ready}, 32'd0);
        chk("rst_out_valid0", {31'd0, if0.out_valid}, 32'd0);
        chk("rst_out_valid8", {31'd0, if8.out_valid}, 32'd0);
        chk("rst_out_data0", if0.out_data, 32'd0);
        chk("rst_out_flags0", {30'd0, if0.out_overflow, if0.out_inexact}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table, back-to-back with out_ready held high
        idx = 0;
        guard = 0;
        while (idx < vecs.size() && guard < 200) begin
            v = vecs[idx];
            if0.in_valid = !v.f8; if0.in_data = v.din;
            if8.in_valid = v.f8;  if8.in_data = v.din;
            nxt0 = '{v.dout, v.ovf, v.inx, 0, 1'b1};
            nxt8 = nxt0;
            sample();
            if (acc0 || acc8) idx++;
            guard++;
            @(negedge clk);
        end
        if0.in_valid = 1'b0;
        if8.in_valid = 1'b0;
        repeat (4) begin
            sample();
            @(negedge clk);
        end
        chk("table_all_sent", idx, vecs.size());
        chk("table_drained", q0.size() + q8.size(), 32'd0);

        // Backpressure: six words, out_ready low for cycles 3..7
        bp_w = '{32'h3F800000, 32'h40000000, 32'h40400000,
                 32'h40800000, 32'h40A00000, 32'h40C00000};
        sent = 0;
        for (int c = 1; c <= 20; c++) begin
            if0.out_ready = !(c >= 3 && c <= 7);
            if0.in_valid  = (sent < 6);
            if0.in_data   = bp_w[(sent < 6) ? sent : 0];
            nxt0 = '{32'(sent + 1), 1'b0, 1'b0, 0, 1'b0};
            sample();
            if (c == 3) chk("bp_absorbed", sent, 32'd2);
            if (c >= 3 && c <= 7) begin
                chk("bp_stall_in_ready", {31'd0, if0.in_ready}, 32'd0);
                chk("bp_stall_valid", {31'd0, if0.out_valid}, 32'd1);
                chk("bp_stall_hold", if0.out_data, 32'd1);
            end
            if (c == 8) chk("bp_ready_rise", {31'd0, if0.in_ready}, 32'd1);
            if (c >= 8 && c <= 13) chk("bp_no_gap", {31'd0, if0.out_valid}, 32'd1);
            if (acc0) sent++;
            @(negedge clk);
        end
        if0.in_valid = 1'b0;
        chk("bp_all_sent", sent, 32'd6);
        chk("bp_drained", q0.size(), 32'd0);

        // Reset with two words in flight
        if0.out_ready = 1'b1;
        if0.in_valid  = 1'b1;
        if0.in_data   = 32'h40400000;
        nxt0 = '{32'd3, 1'b0, 1'b0, 0, 1'b0};
        sample();
        @(negedge clk);
        if0.out_ready = 1'b0;
        if0.in_data   = 32'h40800000;
        nxt0 = '{32'd4, 1'b0, 1'b0, 0, 1'b0};
        sample();
        @(negedge clk);
        if0.in_valid = 1'b0;
        rst = 1'b1;
        sample();
        chk("mid_rst_in_ready", {31'd0, if0.in_ready}, 32'd0);
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        if0.out_ready = 1'b1;
        if0.in_valid  = 1'b1;
        if0.in_data   = 32'hC2F60000;
        nxt0 = '{32'hFFFF_FF85, 1'b0, 1'b0, 0, 1'b1};
        sample();
        chk("post_rst_out_valid", {31'd0, if0.out_valid}, 32'd0);
        chk("post_rst_out_data", if0.out_data, 32'd0);
        chk("post_rst_flags", {30'd0, if0.out_overflow, if0.out_inexact}, 32'd0);
        chk("post_rst_in_ready", {31'd0, if0.in_ready}, 32'd1);
        @(negedge clk);
        if0.in_valid = 1'b0;
        repeat (4) begin
            sample();
            @(negedge clk);
        end
        chk("post_rst_drained", q0.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
